// File: rtl/addressable_register_bank.sv
// Byte-serial addressable register bank: Start, address byte, then a stream of
// write bytes or read requests against an auto-incrementing pointer.
module addressable_register_bank #(
  parameter int AddressWidth = 8,
  parameter int BaseAddress  = 'h00,
  parameter int BitWidth     = 8,
  parameter int Depth        = 8
) (
  input  logic                      CLK,
  input  logic                      _RST,
  input  logic                      Start,
  input  logic                      Stop,
  input  logic                      ByteValid,
  input  logic [BitWidth-1:0]       DataIn,
  input  logic                      ReadReq,
  output logic [BitWidth-1:0]       DataOut,
  output logic                      DataValid,
  output logic                      Error,
  output logic [Depth*BitWidth-1:0] RegOut
);

  localparam logic [AddressWidth-1:0] BaseAddr = AddressWidth'(BaseAddress);
  localparam logic [AddressWidth:0]   DepthExt = (AddressWidth + 1)'(Depth);
  localparam logic [AddressWidth-1:0] LastPtr  = AddressWidth'(Depth - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                  r_state;
  state_e                  w_next_state;
  logic [AddressWidth-1:0] r_pointer;
  logic [AddressWidth-1:0] w_next_ptr;
  logic [BitWidth-1:0]     r_regs [Depth];
  logic [BitWidth-1:0]     r_data_out;
  logic [BitWidth-1:0]     w_rd_data;
  logic                    r_data_valid;
  logic                    r_error;
  logic                    w_in_range;
  logic                    w_load_ptr;
  logic                    w_write;
  logic                    w_read;
  logic                    w_step;
  logic                    w_collide;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!_RST) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Start (repeated start) outranks Stop; both abort whatever the state was doing.
  always_comb begin
    w_next_state = r_state;
    if (Start)     w_next_state = ADDR;
    else if (Stop) w_next_state = IDLE;
    else begin
      case (r_state)
        IDLE:    w_next_state = IDLE;
        ADDR:    if (ByteValid) w_next_state = DATA;
        DATA:    w_next_state = DATA;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output is defaulted first so no latch is inferred.
  always_comb begin
    w_load_ptr = 1'b0;
    w_write    = 1'b0;
    w_read     = 1'b0;
    w_step     = 1'b0;
    w_collide  = 1'b0;
    if (!Start && !Stop) begin
      case (r_state)
        ADDR: w_load_ptr = ByteValid;
        DATA: begin
          w_write   = ByteValid;
          w_read    = ReadReq && !ByteValid;
          w_collide = ByteValid && ReadReq;
          w_step    = ByteValid || ReadReq;
        end
        default: ;
      endcase
    end
  end

  assign w_in_range = {1'b0, r_pointer} < DepthExt;
  assign w_next_ptr = (r_pointer == LastPtr) ? '0 : r_pointer + 1'b1;

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < Depth; k++) begin
      if (r_pointer == AddressWidth'(k)) w_rd_data = r_regs[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (!_RST) begin
      r_pointer    <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      if (w_load_ptr)  r_pointer <= DataIn[AddressWidth-1:0] - BaseAddr;
      else if (w_step) r_pointer <= w_next_ptr;
      r_data_valid <= w_read;
      if (w_read) r_data_out <= w_in_range ? w_rd_data : '0;
      if (w_collide || ((w_write || w_read) && !w_in_range)) r_error <= 1'b1;
    end
  end

  // NOTE: the bank is built from flops, so it is cleared by reset like any other state.
  always_ff @(posedge CLK) begin
    if (!_RST) begin
      for (int k = 0; k < Depth; k++) r_regs[k] <= '0;
    end else begin
      for (int k = 0; k < Depth; k++) begin
        if (w_write && r_pointer == AddressWidth'(k)) r_regs[k] <= DataIn;
      end
    end
  end

  for (genvar k = 0; k < Depth; k++) begin : g_reg_out
    assign RegOut[k*BitWidth +: BitWidth] = r_regs[k];
  end

  assign DataOut   = r_data_out;
  assign DataValid = r_data_valid;
  assign Error     = r_error;

endmodule

// File: tb/tb_addressable_register_bank.sv
// Directed bench for addressable_register_bank with default parameters
// (8-bit address, base 0, 8-bit data, 8 registers).
module tb_addressable_register_bank;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        Start, Stop, ByteValid, ReadReq;
  logic [7:0]  DataIn;
  logic [7:0]  DataOut;
  logic        DataValid, Error;
  logic [63:0] RegOut;

  int passed = 0;
  int total  = 0;

  addressable_register_bank dut (
    .CLK       (CLK),
    ._RST      (rst_n),
    .Start     (Start),
    .Stop      (Stop),
    .ByteValid (ByteValid),
    .DataIn    (DataIn),
    .ReadReq   (ReadReq),
    .DataOut   (DataOut),
    .DataValid (DataValid),
    .Error     (Error),
    .RegOut    (RegOut)
  );

  always #5 CLK = ~CLK;

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic st, input logic sp, input logic bv,
                      input logic [7:0] d, input logic rr);
    Start = st; Stop = sp; ByteValid = bv; DataIn = d; ReadReq = rr;
    @(posedge CLK);
    #1;
    Start = 1'b0; Stop = 1'b0; ByteValid = 1'b0; DataIn = 8'h00; ReadReq = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 8'h00, 0);
    step(1, 0, 1, 8'h03, 1);
    total++; if (RegOut !== 64'h0) $display("FAIL reset_regout: got %h want %h", RegOut, 64'h0); else passed++;
    total++; if (DataOut !== 8'h00) $display("FAIL reset_dataout: got %h want 00", DataOut); else passed++;
    total++; if ({DataValid, Error} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {DataValid, Error}); else passed++;
    rst_n = 1'b1;
    step(0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_write_burst();
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h02, 0);
    step(0, 0, 1, 8'hA5, 0);
    total++; if (RegOut[23:16] !== 8'hA5) $display("FAIL write_latency: got %h want a5", RegOut[23:16]); else passed++;
    step(0, 0, 1, 8'h5A, 0);
    step(0, 1, 0, 8'h00, 0);
    total++; if (RegOut !== 64'h00000000_5AA50000) $display("FAIL burst_regout: got %h want %h", RegOut, 64'h00000000_5AA50000); else passed++;
    total++; if (Error !== 1'b0) $display("FAIL burst_error: got %b want 0", Error); else passed++;
  endtask

  task automatic test_wrap();
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h07, 0);
    step(0, 0, 1, 8'h11, 0);
    step(0, 0, 1, 8'h22, 0);
    step(0, 1, 0, 8'h00, 0);
    total++; if (RegOut !== 64'h11000000_5AA50022) $display("FAIL wrap_regout: got %h want %h", RegOut, 64'h11000000_5AA50022); else passed++;
    total++; if (Error !== 1'b0) $display("FAIL wrap_error: got %b want 0", Error); else passed++;
  endtask

  task automatic test_back_to_back_read();
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h02, 0);
    step(0, 0, 0, 8'h00, 1);
    total++; if ({DataValid, DataOut} !== {1'b1, 8'hA5}) $display("FAIL read0: got dv=%b data=%h want dv=1 data=a5", DataValid, DataOut); else passed++;
    step(0, 0, 0, 8'h00, 1);
    total++; if ({DataValid, DataOut} !== {1'b1, 8'h5A}) $display("FAIL read1: got dv=%b data=%h want dv=1 data=5a", DataValid, DataOut); else passed++;
    step(0, 0, 0, 8'h00, 0);
    total++; if (DataValid !== 1'b0) $display("FAIL read_pulse: got dv=%b want 0", DataValid); else passed++;
    step(0, 1, 0, 8'h00, 0);
  endtask

  task automatic test_discard();
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h04, 0);
    // Stop+Start with a byte: byte dropped, lands in ADDR.
    step(1, 1, 1, 8'h66, 0);
    step(0, 0, 1, 8'h06, 0);
    step(0, 0, 1, 8'h77, 0);
    step(0, 1, 1, 8'h88, 0);
    total++; if (RegOut !== 64'h11770000_5AA50022) $display("FAIL discard_regout: got %h want %h", RegOut, 64'h11770000_5AA50022); else passed++;
    step(0, 0, 1, 8'h99, 1);
    total++; if ({DataValid, RegOut} !== {1'b0, 64'h11770000_5AA50022}) $display("FAIL idle_ignore: got dv=%b regs=%h want dv=0 regs=%h", DataValid, RegOut, 64'h11770000_5AA50022); else passed++;
  endtask

  task automatic test_out_of_range();
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h20, 0);
    step(0, 0, 1, 8'hFF, 0);
    total++; if (RegOut !== 64'h11770000_5AA50022) $display("FAIL oor_write_regout: got %h want %h", RegOut, 64'h11770000_5AA50022); else passed++;
    total++; if (Error !== 1'b1) $display("FAIL oor_write_error: got %b want 1", Error); else passed++;
    step(0, 0, 0, 8'h00, 1);
    total++; if ({DataValid, DataOut} !== {1'b1, 8'h00}) $display("FAIL oor_read: got dv=%b data=%h want dv=1 data=00", DataValid, DataOut); else passed++;
    step(0, 1, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    total++; if (Error !== 1'b1) $display("FAIL error_sticky: got %b want 1", Error); else passed++;
    rst_n = 1'b0;
    step(0, 0, 0, 8'h00, 0);
    rst_n = 1'b1;
    total++; if ({Error, RegOut} !== {1'b0, 64'h0}) $display("FAIL error_clear: got err=%b regs=%h want err=0 regs=0", Error, RegOut); else passed++;
  endtask

  task automatic test_collision();
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h05, 0);
    step(0, 0, 1, 8'h99, 0);
    step(0, 1, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h04, 0);
    step(0, 0, 1, 8'h3C, 1);
    total++; if (RegOut !== 64'h0000993C_00000000) $display("FAIL collide_regout: got %h want %h", RegOut, 64'h0000993C_00000000); else passed++;
    total++; if ({DataValid, Error} !== 2'b01) $display("FAIL collide_flags: got dv,err=%b want 01", {DataValid, Error}); else passed++;
    step(0, 0, 0, 8'h00, 1);
    total++; if ({DataValid, DataOut} !== {1'b1, 8'h99}) $display("FAIL collide_ptr: got dv=%b data=%h want dv=1 data=99", DataValid, DataOut); else passed++;
    step(0, 1, 0, 8'h00, 0);
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h00, 0);
    rst_n = 1'b0;
    step(0, 0, 1, 8'h77, 0);
    rst_n = 1'b1;
    total++; if (RegOut !== 64'h0) $display("FAIL midreset_regout: got %h want 0", RegOut); else passed++;
    total++; if ({DataValid, Error, DataOut} !== 10'h0) $display("FAIL midreset_outs: got dv=%b err=%b data=%h want all 0", DataValid, Error, DataOut); else passed++;
    step(0, 0, 1, 8'h55, 0);
    step(0, 0, 0, 8'h00, 1);
    total++; if ({DataValid, RegOut} !== {1'b0, 64'h0}) $display("FAIL midreset_idle: got dv=%b regs=%h want dv=0 regs=0", DataValid, RegOut); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    Start = 1'b0; Stop = 1'b0; ByteValid = 1'b0; DataIn = 8'h00; ReadReq = 1'b0;
    test_reset();
    test_write_burst();
    test_wrap();
    test_back_to_back_read();
    test_discard();
    test_out_of_range();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/addressable_register_bank.md
ADDRESSABLE_REGISTER_BANK -- requirements
Module: addressable_register_bank

Interface
REQ-001 SHALL have parameter AddressWidth, default 8: width of register address space.
REQ-002 SHALL have parameter BaseAddress, default 'h00: address of register 0.
REQ-003 SHALL have parameter BitWidth, default 8: data width per register and per bus byte; BitWidth >= AddressWidth.
REQ-004 SHALL have parameter Depth, default 8: number of registers, 1..2^AddressWidth.
REQ-005 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port _RST  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port Start  input  1  one-cycle pulse opening a transaction.
REQ-008 SHALL have port Stop  input  1  one-cycle pulse closing a transaction.
REQ-009 SHALL have port ByteValid  input  1  DataIn holds a valid byte this cycle.
REQ-010 SHALL have port DataIn  input  BitWidth  address or write-data byte.
REQ-011 SHALL have port ReadReq  input  1  request the register at the pointer.
REQ-012 SHALL have port DataOut  output  BitWidth  registered read data.
REQ-013 SHALL have port DataValid  output  1  one-cycle pulse, DataOut valid.
REQ-014 SHALL have port Error  output  1  sticky flag: out-of-range access or collision.
REQ-015 SHALL have port RegOut  output  Depth*BitWidth  all registers in parallel, register k at bits [k*BitWidth +: BitWidth].

Function
REQ-016 SHALL implement states IDLE, ADDR, DATA.
REQ-017 IDLE: Start -> ADDR; ByteValid and ReadReq ignored.
REQ-018 ADDR: ByteValid -> Pointer = DataIn[AddressWidth-1:0] - BaseAddress (AddressWidth-bit modulo), go DATA.
REQ-019 DATA: ByteValid writes DataIn to register[Pointer] if in range; Pointer increments next cycle.
REQ-020 DATA: ReadReq loads DataOut = register[Pointer] (0 if out of range), DataValid=1 next cycle, Pointer increments.
REQ-021 Pointer in range SHALL mean Pointer < Depth; increment from Depth-1 SHALL wrap to 0.
REQ-022 Out-of-range write SHALL leave all registers unchanged and set Error.
REQ-023 Out-of-range read SHALL return 0, assert DataValid and set Error.
REQ-024 Stop in any state -> IDLE; a ByteValid or ReadReq in the same cycle SHALL be discarded.
REQ-025 Start in ADDR or DATA SHALL restart -> ADDR (repeated start); same-cycle ByteValid/ReadReq discarded; Stop+Start same cycle -> ADDR.
REQ-026 ByteValid and ReadReq in same DATA cycle: write performed, read dropped, no DataValid, Error set, Pointer +1 once.
REQ-027 Write latency: RegOut reflects written byte on the cycle after ByteValid.
REQ-028 Read-after-write to same register in consecutive cycles SHALL return the new value.
REQ-029 DataValid SHALL be low in every cycle not immediately following an accepted read.
REQ-030 Error SHALL clear only on reset.
REQ-031 Pointer SHALL persist across Stop; IDLE does not modify it.

Reset
REQ-032 _RST low at a clock edge SHALL set all registers, RegOut, DataOut, Pointer to 0, DataValid and Error to 0, state IDLE.
REQ-033 Reset SHALL take priority over Start, Stop, ByteValid, ReadReq in the same cycle.
REQ-034 Reset mid-transaction SHALL abort it; no write from that cycle lands.

Verification
REQ-035 Start, ByteValid 'h02, ByteValid 'hA5, 'h5A, Stop -> reg2='hA5, reg3='h5A, others 0, Error 0.
REQ-036 Depth=8, Start, addr 'h07, write 'h11, 'h22 -> reg7='h11, reg0='h22 (wrap).
REQ-037 Start, addr 'h02, ReadReq x2 after REQ-035 -> DataOut 'hA5 then 'h5A, each with 1-cycle DataValid.
REQ-038 Start, addr 'h20, write 'hFF, ReadReq -> no register changes, DataOut 0, DataValid 1, Error 1 until reset.
REQ-039 ByteValid+ReadReq same cycle in DATA at pointer 4, DataIn 'h3C -> reg4='h3C, no DataValid, Error 1, Pointer 5.
REQ-040 Reset asserted during DATA with ByteValid 'h77 -> no write, all outputs 0, state IDLE; next ByteValid without Start ignored.
